imem_loader: RTL and testbench

Boot-time writer for the single-cycle MIPS instruction memory. It accepts a framed byte stream from a byte-level receiver, such as the UART RX, over a valid/ready handshake. It assembles little-endian 32-bit instruction words and writes them to consecutive imem word addresses starting at 0. It holds the CPU in reset until a complete frame with a correct checksum has been loaded.

---
 rtl/imem_loader_pkg.sv | 35 +++
 rtl/imem_loader_word_assembler.sv | 54 +++++
 rtl/imem_loader.sv | 103 ++++++++++
 tb/tb_imem_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Holds the loader state encoding, the frame start byte default and the frame layout.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // Frame field order as it appears on the byte stream.
   typedef enum logic [2:0] {
      FLD_SYNC,
      FLD_LEN_LO,
      FLD_LEN_HI,
      FLD_PAYLOAD,
      FLD_CSUM
   } field_t;

   localparam int unsigned LEN_BYTES      = 2;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned CSUM_BYTES     = 1;

   // A frame is rejected if it would write past the last imem word.
   function automatic logic len_oversize(input logic [15:0] n, input int unsigned addr_w);
      return {16'b0, n} > (32'd1 << addr_w);
   endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Per-word byte assembler: places little-endian bytes into lanes and
// emits one registered imem write strobe when the fourth byte arrives.
module word_assembler
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              byte_en,
   input  logic [7:0]        byte_in,
   input  logic [ADDR_W-1:0] addr,
   output logic              word_done,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata
);

   logic [1:0]  lane;
   logic [23:0] low_bytes;

   assign word_done = byte_en && (lane == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane      <= '0;
         low_bytes <= '0;
         we        <= 1'b0;
         waddr     <= '0;
         wdata     <= '0;
      end else begin
         we <= word_done;
         if (clr) begin
            lane <= '0;
         end else if (byte_en) begin
            lane <= lane + 2'd1;
            case (lane)
               2'd0:    low_bytes[7:0]   <= byte_in;
               2'd1:    low_bytes[15:8]  <= byte_in;
               2'd2:    low_bytes[23:16] <= byte_in;
               default: low_bytes        <= low_bytes;
            endcase
         end
         // The top byte goes straight into the write word so the strobe
         // can follow the fourth byte by exactly one cycle.
         if (word_done) begin
            wdata <= {byte_in, low_bytes};
            waddr <= addr;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time imem writer: parses SYNC/LEN/payload/CSUM frames from a byte
// stream, writes words from address 0 and releases the CPU on a good checksum.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 11,
   parameter logic [7:0]  SYNC   = SYNC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              error
);

   state_t            state, state_nxt;
   logic [7:0]        len_lo;
   logic [15:0]       len;
   logic [15:0]       len_rx;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        acc;
   logic              accept;
   logic              start;
   logic              data_en;
   logic              word_done;
   logic              last_word;

   assign in_ready  = 1'b1;
   assign accept    = in_valid && in_ready;
   assign start     = accept && (in_data == SYNC) &&
                      ((state == IDLE) || (state == DONE) || (state == ERR));
   assign data_en   = accept && (state == DATA);
   assign len_rx    = {in_data, len_lo};
   // len is bounded to 2**ADDR_W, so its low bits minus one name the last word.
   assign last_word = word_done && (addr == ADDR_W'(len - 16'd1));

   word_assembler #(
      .ADDR_W (ADDR_W)
   ) u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (start),
      .byte_en   (data_en),
      .byte_in   (in_data),
      .addr      (addr),
      .word_done (word_done),
      .we        (imem_we),
      .waddr     (imem_waddr),
      .wdata     (imem_wdata)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: if (start) state_nxt = LEN0;
         LEN0:            if (accept) state_nxt = LEN1;
         LEN1: begin
            if (accept) begin
               if (len_oversize(len_rx, ADDR_W)) state_nxt = ERR;
               else if (len_rx == 16'd0)         state_nxt = CSUM;
               else                              state_nxt = DATA;
            end
         end
         DATA:            if (last_word) state_nxt = CSUM;
         CSUM:            if (accept) state_nxt = (in_data == acc) ? DONE : ERR;
         default:         state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         len_lo  <= '0;
         len     <= '0;
         addr    <= '0;
         acc     <= '0;
         cpu_rst <= 1'b1;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cpu_rst <= (state_nxt != DONE);
         done    <= (state_nxt == DONE);
         error   <= (state_nxt == ERR);
         if (start) begin
            acc  <= '0;
            addr <= '0;
            len  <= '0;
         end
         if (accept && (state == LEN0)) len_lo <= in_data;
         if (accept && (state == LEN1)) len <= len_rx;
         if (data_en)   acc  <= acc ^ in_data;
         if (word_done) addr <= addr + 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: scoreboard of expected imem writes
// plus status checks after each frame.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int unsigned ADDR_W = 11;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst;
   logic              done;
   logic              error;

   int unsigned compared   = 0;
   int unsigned mismatched = 0;
   int unsigned wr_seen    = 0;
   int unsigned wr_expect  = 0;
   wr_t         exp_q[$];
   logic [31:0] frame_words[$];

   imem_loader #(
      .ADDR_W (ADDR_W),
      .SYNC   (8'hA5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_t e;
         wr_seen++;
         if (exp_q.size() == 0) begin
            check("unexpected_we", 32'(imem_waddr), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(imem_waddr), 32'(e.addr));
            check("wr_data", imem_wdata, e.data);
         end
      end
   end

   function automatic int unsigned pick_gap(input int unsigned m);
      return (m == 0) ? 0 : $urandom_range(m, 0);
   endfunction

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] n, input bit bad_csum, input int unsigned max_gap);
      logic [7:0]  cs;
      logic [31:0] w;
      cs = '0;
      send_byte(8'hA5, pick_gap(max_gap));
      send_byte(n[7:0], pick_gap(max_gap));
      send_byte(n[15:8], pick_gap(max_gap));
      foreach (frame_words[i]) begin
         w = frame_words[i];
         exp_q.push_back('{addr: ADDR_W'(i), data: w});
         wr_expect++;
         for (int b = 0; b < 4; b++) begin
            send_byte(w[8*b +: 8], pick_gap(max_gap));
            cs = cs ^ w[8*b +: 8];
         end
         check("we_latency", 32'(imem_we), 32'd1);
      end
      check("done_before_csum", 32'(done), 32'd0);
      send_byte(bad_csum ? (cs ^ 8'h01) : cs, pick_gap(max_gap));
   endtask

   task automatic expect_status(input string tag, input logic c, input logic d, input logic e);
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(c));
      check({tag, "_done"},    32'(done),    32'(d));
      check({tag, "_error"},   32'(error),   32'(e));
   endtask

   task automatic load_nominal();
      frame_words.delete();
      frame_words.push_back(32'h0010_013C);
      frame_words.push_back(32'h0800_0000);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      expect_status("reset", 1'b1, 1'b0, 1'b0);
      check("reset_we",    32'(imem_we), 32'd0);
      check("reset_waddr", 32'(imem_waddr), 32'd0);
      check("reset_wdata", imem_wdata, 32'd0);
      check("in_ready",    32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Nominal two-word image; checksum is 0x25.
      load_nominal();
      send_frame(16'd2, 1'b0, 0);
      expect_status("nominal", 1'b0, 1'b1, 1'b0);

      // Same frame with a corrupted checksum.
      send_frame(16'd2, 1'b1, 0);
      expect_status("bad_csum", 1'b1, 1'b0, 1'b1);

      // Length 0x0801 exceeds 2048 words: ERR right after LEN_HI, no writes.
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      check("oversize_err_pending", 32'(error), 32'd0);
      send_byte(8'h08, 0);
      expect_status("oversize", 1'b1, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      send_frame(16'd2, 1'b0, 0);
      expect_status("recover", 1'b0, 1'b1, 1'b0);

      // Empty image.
      frame_words.delete();
      send_frame(16'd0, 1'b0, 0);
      expect_status("n_zero", 1'b0, 1'b1, 1'b0);

      // Random inter-byte gaps, nominal and a three-word random image.
      load_nominal();
      send_frame(16'd2, 1'b0, 20);
      expect_status("gaps_nominal", 1'b0, 1'b1, 1'b0);
      frame_words.delete();
      for (int i = 0; i < 3; i++) frame_words.push_back($urandom);
      send_frame(16'd3, 1'b0, 20);
      expect_status("gaps_random", 1'b0, 1'b1, 1'b0);

      // Reset during word 1 of a frame.
      load_nominal();
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      exp_q.push_back('{addr: '0, data: 32'h0010_013C});
      wr_expect++;
      send_byte(8'h3C, 0);
      send_byte(8'h01, 0);
      send_byte(8'h10, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      rst_n = 1'b0;
      @(negedge clk);
      expect_status("midreset", 1'b1, 1'b0, 1'b0);
      check("midreset_we",    32'(imem_we), 32'd0);
      check("midreset_waddr", 32'(imem_waddr), 32'd0);
      check("midreset_wdata", imem_wdata, 32'd0);
      rst_n = 1'b1;
      send_byte(8'h00, 1);
      send_byte(8'hFF, 0);
      send_byte(8'h5A, 2);
      expect_status("junk", 1'b1, 1'b0, 1'b0);
      send_frame(16'd2, 1'b0, 0);
      expect_status("reload", 1'b0, 1'b1, 1'b0);

      // SYNC while DONE restarts the load.
      send_byte(8'hA5, 0);
      expect_status("resync", 1'b1, 1'b0, 1'b0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      expect_status("resync_done", 1'b0, 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("write_count", wr_seen, wr_expect);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
